uart_price_parser: RTL

Frame parser directly downstream of `uart_rx`. Consumes the received byte stream (`uart_rx_valid` / `uart_rx_data`) and assembles fixed-length price-update frames. Checks each frame's ID range and XOR checksum, then emits one registered price record per good frame to the arbitrage logic. Malformed or stalled frames are dropped and reported on single-cycle error strobes.

---
 rtl/uart_price_parser.sv | 113 +++++++++++
 1 files changed

// File: rtl/uart_price_parser.sv
// uart_price_parser: assembles SOF/ID/price/XOR-checksum frames from a UART byte stream into price records.
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   rx_valid, rx_data       one-cycle received-byte strobe and its byte
//   price_valid             one-cycle strobe marking a good frame on price_id/price_data
//   price_id, price_data    exchange ID and big-endian price of the last good frame
//   err_csum, err_id        one-cycle strobes for checksum mismatch / out-of-range ID
//   err_timeout             one-cycle strobe when a frame stalls between bytes
//   busy                    high while a frame is in progress
module uart_price_parser #(
    parameter int PRICE_BYTES    = 4,
    parameter int NUM_IDS        = 4,
    parameter logic [7:0] SOF_BYTE = 8'hA5,
    parameter int TIMEOUT_CYCLES = 104_160
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_data,
    output logic                     price_valid,
    output logic [7:0]               price_id,
    output logic [8*PRICE_BYTES-1:0] price_data,
    output logic                     err_csum,
    output logic                     err_id,
    output logic                     err_timeout,
    output logic                     busy
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW = $clog2(PRICE_BYTES + 1);
    localparam int PW = 8 * PRICE_BYTES;
    localparam logic [8:0] NID = 9'(NUM_IDS);

    typedef enum logic [1:0] {IDLE, ID, PRICE, CSUM} state_t;

    state_t         state, state_nxt;
    logic [TW-1:0]  tcnt;
    logic [BW-1:0]  bcnt;
    logic [7:0]     xsum;
    logic [7:0]     id_q;
    logic [PW-1:0]  shift;
    logic [PW+7:0]  shift_ext;
    logic           good, bad_csum, bad_id, tout;

    assign shift_ext = {shift, rx_data};

    always_comb begin
        state_nxt = state;
        good      = 1'b0;
        bad_csum  = 1'b0;
        bad_id    = 1'b0;
        tout      = 1'b0;
        if (rx_valid) begin
            case (state)
                IDLE:  state_nxt = (rx_data == SOF_BYTE) ? ID : IDLE;
                ID: begin
                    bad_id    = ({1'b0, rx_data} >= NID);
                    state_nxt = bad_id ? IDLE : PRICE;
                end
                PRICE: state_nxt = (bcnt == BW'(PRICE_BYTES - 1)) ? CSUM : PRICE;
                default: begin
                    good      = (rx_data == xsum);
                    bad_csum  = !good;
                    state_nxt = IDLE;
                end
            endcase
        end else if (state != IDLE && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            // the counter would reach its limit on this edge; a byte in this cycle would have won
            tout      = 1'b1;
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            tcnt        <= '0;
            bcnt        <= '0;
            xsum        <= '0;
            id_q        <= '0;
            shift       <= '0;
            price_valid <= 1'b0;
            price_id    <= '0;
            price_data  <= '0;
            err_csum    <= 1'b0;
            err_id      <= 1'b0;
            err_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            price_valid <= good;
            err_csum    <= bad_csum;
            err_id      <= bad_id;
            err_timeout <= tout;
            busy        <= (state_nxt != IDLE);
            tcnt        <= (state == IDLE || rx_valid) ? '0 :
                           (tcnt == TW'(TIMEOUT_CYCLES)) ? tcnt : tcnt + 1'b1;
            if (rx_valid && state == ID) begin
                id_q <= rx_data;
                xsum <= rx_data;
                bcnt <= '0;
            end
            if (rx_valid && state == PRICE) begin
                shift <= shift_ext[PW-1:0];
                xsum  <= xsum ^ rx_data;
                bcnt  <= bcnt + 1'b1;
            end
            if (good) begin
                price_id   <= id_q;
                price_data <= shift;
            end
        end
    end
endmodule
